knight_cmd_seq: RTL and testbench

Parametrised command sequencer for the Knight robot, between the UART/command wrapper and the inertial interface, PID controller and tour logic. It buffers incoming 16-bit commands in a small queue and executes them in order: calibrate, move with or without fanfare, and tour hand-off. It adds an immediate STOP that aborts motion and flushes the queue, saturating speed ramps, and coded responses for success and failure.

---
 rtl/knight_pkg.sv | 27 ++
 rtl/knight_cmd_fifo.sv | 49 ++++
 rtl/knight_cmd_seq.sv | 211 +++++++++++++++++++++
 tb/tb_knight_cmd_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knight_pkg.sv
// Shared opcodes, response codes and FSM state type for the Knight command sequencer.
package knight_pkg;

   localparam logic [3:0] OP_CAL    = 4'h2;
   localparam logic [3:0] OP_MOVE   = 4'h4;
   localparam logic [3:0] OP_MOVE_F = 4'h5;
   localparam logic [3:0] OP_TOUR   = 4'h6;
   localparam logic [3:0] OP_STOP   = 4'h7;

   localparam logic [7:0] RESP_ACK  = 8'hA5;
   localparam logic [7:0] RESP_NAK  = 8'h5A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAL,
      ST_ALIGN,
      ST_RAMP_UP,
      ST_RAMP_DOWN,
      ST_TOUR
   } state_t;

   // Opcodes that go through the queue; STOP and illegal codes never do.
   function automatic logic is_queued_op(input logic [3:0] op);
      return op inside {OP_CAL, OP_MOVE, OP_MOVE_F, OP_TOUR};
   endfunction

endpackage

// File: rtl/knight_cmd_fifo.sv
// Command queue: 16-bit entries, read data shows the head, extra pointer bit separates full from empty.
module knight_cmd_fifo #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  logic [15:0] wr_data,
   output logic [15:0] rd_data,
   output logic        full,
   output logic        empty
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [15:0] mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // NOTE: storage has no reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/knight_cmd_seq.sv
// Knight command sequencer: queues commands and runs calibrate, move (with optional fanfare)
// and tour hand-off, with an immediate STOP, saturating speed ramps and coded responses.
module knight_cmd_seq
   import knight_pkg::*;
#(
   parameter int                FAST_SIM = 1,
   parameter int                FRWRD_W  = 10,
   parameter int                HEAD_W   = 12,
   parameter int                Q_DEPTH  = 4,
   parameter logic [HEAD_W-1:0] ERR_TOL  = HEAD_W'('h02C)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [15:0]        cmd,
   input  logic               cmd_rdy,
   output logic               clr_cmd_rdy,
   output logic               send_resp,
   output logic [7:0]         resp,
   output logic               q_full,
   output logic               tour_go,
   input  logic [HEAD_W-1:0]  heading,
   input  logic               heading_rdy,
   output logic               strt_cal,
   input  logic               cal_done,
   output logic               moving,
   input  logic               lftIR,
   input  logic               cntrIR,
   input  logic               rghtIR,
   output logic               fanfare_go,
   output logic [FRWRD_W-1:0] frwrd,
   output logic [HEAD_W-1:0]  error
);

   localparam logic [FRWRD_W-1:0] INCR      = (FAST_SIM != 0) ? FRWRD_W'(32'h20) : FRWRD_W'(32'h03);
   localparam logic [FRWRD_W-1:0] DECR      = {INCR[FRWRD_W-2:0], 1'b0};
   localparam int                 NUDGE_L_I = (FAST_SIM != 0) ? 511 : 95;
   localparam int                 NUDGE_R_I = (FAST_SIM != 0) ? -512 : -95;
   localparam logic [HEAD_W-1:0]  NUDGE_L   = HEAD_W'(NUDGE_L_I);
   localparam logic [HEAD_W-1:0]  NUDGE_R   = HEAD_W'(NUDGE_R_I);

   state_t               state_q, state_d;
   logic [3:0]           cmd_op;
   logic                 stop_now, illegal_acc, push, pop;
   logic [15:0]          q_head;
   logic                 q_empty;
   logic                 latch_mv, abort_set, fsm_resp;
   logic [7:0]           fsm_code;
   logic [3:0]           op_q;
   logic [2:0]           squares_q;
   logic [HEAD_W-1:0]    desired_q, desired_d, nudge;
   logic signed [11:0]   des12;
   logic                 aborted_q;
   logic [3:0]           box_cnt;
   logic [2:0]           cntr_sync;
   logic                 cntr_rise;
   logic [FRWRD_W-1:0]   frwrd_q;
   logic signed [HEAD_W-1:0] err_s, tol_s;
   logic                 aligned;
   logic                 unused_q_bit;

   assign cmd_op       = cmd[15:12];
   assign stop_now     = cmd_rdy && (cmd_op == OP_STOP);
   assign push         = cmd_rdy && is_queued_op(cmd_op) && (!q_full || pop);
   assign illegal_acc  = cmd_rdy && !is_queued_op(cmd_op) && (cmd_op != OP_STOP) && !fsm_resp;
   assign clr_cmd_rdy  = push || stop_now || illegal_acc;
   assign unused_q_bit = q_head[3];

   knight_cmd_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .flush   (stop_now),
      .wr_data (cmd),
      .rd_data (q_head),
      .full    (q_full),
      .empty   (q_empty)
   );

   // Heading byte zero maps to an exact multiple of 16; otherwise the low nibble is filled.
   assign des12     = (q_head[11:4] == 8'h00) ? {q_head[11:4], 4'h0} : {q_head[11:4], 4'hF};
   assign desired_d = HEAD_W'(des12);
   assign nudge     = lftIR ? NUDGE_L : (rghtIR ? NUDGE_R : '0);
   assign error     = heading - desired_q + nudge;
   assign err_s     = error;
   assign tol_s     = ERR_TOL;
   assign aligned   = (err_s < tol_s) && (err_s > -tol_s);
   assign cntr_rise = cntr_sync[1] && !cntr_sync[2];
   assign moving    = (state_q == ST_ALIGN) || (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
   assign frwrd     = frwrd_q;

   // NOTE: every output of this block gets a default first so no path leaves a latch behind.
   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      latch_mv   = 1'b0;
      abort_set  = 1'b0;
      strt_cal   = 1'b0;
      fanfare_go = 1'b0;
      tour_go    = 1'b0;
      fsm_resp   = 1'b0;
      fsm_code   = RESP_ACK;
      case (state_q)
         ST_IDLE: begin
            if (!q_empty && !stop_now) begin
               pop = 1'b1;
               case (q_head[15:12])
                  OP_CAL: begin
                     strt_cal = 1'b1;
                     state_d  = ST_CAL;
                  end
                  OP_MOVE, OP_MOVE_F: begin
                     latch_mv = 1'b1;
                     state_d  = ST_ALIGN;
                  end
                  OP_TOUR: state_d = ST_TOUR;
                  default: state_d = ST_IDLE;
               endcase
            end
         end
         ST_CAL: begin
            if (cal_done) begin
               fsm_resp = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_ALIGN: begin
            if (stop_now) begin
               abort_set = 1'b1;
               state_d   = ST_RAMP_DOWN;
            end else if (aligned) begin
               state_d = ST_RAMP_UP;
            end
         end
         ST_RAMP_UP: begin
            if (stop_now) begin
               abort_set = 1'b1;
               state_d   = ST_RAMP_DOWN;
            end else if (box_cnt == {squares_q, 1'b0}) begin
               fanfare_go = (op_q == OP_MOVE_F);
               state_d    = ST_RAMP_DOWN;
            end
         end
         ST_RAMP_DOWN: begin
            if (frwrd_q == '0) begin
               fsm_resp = 1'b1;
               fsm_code = aborted_q ? RESP_NAK : RESP_ACK;
               state_d  = ST_IDLE;
            end
         end
         ST_TOUR: begin
            tour_go = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      send_resp = fsm_resp || illegal_acc || (stop_now && (state_q == ST_IDLE));
      resp      = '0;
      if (fsm_resp)       resp = fsm_code;
      else if (send_resp) resp = RESP_NAK;
   end

   // NOTE: state and datapath registers use non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         squares_q <= '0;
         desired_q <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (latch_mv) begin
            op_q      <= q_head[15:12];
            squares_q <= q_head[2:0];
            desired_q <= desired_d;
            aborted_q <= 1'b0;
         end else if (abort_set) begin
            aborted_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cntr_sync <= '0;
         box_cnt   <= '0;
      end else begin
         cntr_sync <= {cntr_sync[1:0], cntrIR};
         if (latch_mv)       box_cnt <= '0;
         else if (cntr_rise) box_cnt <= box_cnt + 4'd1;
      end
   end

   // Ramp up saturates once the top two bits are set; ramp down clamps at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frwrd_q <= '0;
      end else if (heading_rdy) begin
         if (state_q == ST_RAMP_UP) begin
            if (!(&frwrd_q[FRWRD_W-1 -: 2])) frwrd_q <= frwrd_q + INCR;
         end else if (state_q == ST_RAMP_DOWN) begin
            frwrd_q <= (frwrd_q < DECR) ? '0 : frwrd_q - DECR;
         end
      end
   end

endmodule

// File: tb/tb_knight_cmd_seq.sv
// Directed self-checking bench for knight_cmd_seq with hand-computed expectations.
module tb_knight_cmd_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy, send_resp, q_full, tour_go, strt_cal, moving, fanfare_go;
   logic [7:0]  resp;
   logic [11:0] heading;
   logic        heading_rdy, cal_done, lftIR, cntrIR, rghtIR;
   logic [9:0]  frwrd;
   logic [11:0] error;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          resp_cnt = 0;
   int          ff_cnt   = 0;
   int          tour_cnt = 0;
   int          cal_cnt  = 0;
   logic [7:0]  last_resp = '0;
   logic        moving_prev = 1'b0;
   logic [11:0] err_log [$];

   always #5 clk = ~clk;

   knight_cmd_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .send_resp   (send_resp),
      .resp        (resp),
      .q_full      (q_full),
      .tour_go     (tour_go),
      .heading     (heading),
      .heading_rdy (heading_rdy),
      .strt_cal    (strt_cal),
      .cal_done    (cal_done),
      .moving      (moving),
      .lftIR       (lftIR),
      .cntrIR      (cntrIR),
      .rghtIR      (rghtIR),
      .fanfare_go  (fanfare_go),
      .frwrd       (frwrd),
      .error       (error)
   );

   // Mid-cycle observer of the one-cycle strobes and of the error seen as each move starts.
   always @(negedge clk) begin
      if (send_resp) begin
         resp_cnt++;
         last_resp = resp;
      end
      if (fanfare_go) ff_cnt++;
      if (tour_go)    tour_cnt++;
      if (strt_cal)   cal_cnt++;
      if (moving && !moving_prev) err_log.push_back(error);
      moving_prev = moving;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_cmd(input logic [15:0] c);
      int n = 0;
      cmd     = c;
      cmd_rdy = 1'b1;
      #1;
      while (!clr_cmd_rdy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check($sformatf("accept_%h", c), clr_cmd_rdy, 1);
      @(posedge clk);
      #1;
      cmd_rdy = 1'b0;
   endtask

   task automatic hdg_pulses(input int n);
      heading_rdy = 1'b1;
      tick(n);
      heading_rdy = 1'b0;
   endtask

   task automatic cntr_pulse();
      cntrIR = 1'b1;
      tick(2);
      cntrIR = 1'b0;
      tick(2);
   endtask

   task automatic wait_resp(input string tag, input logic [7:0] exp);
      int base = resp_cnt;
      int n    = 0;
      heading_rdy = 1'b1;
      while (resp_cnt == base && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      heading_rdy = 1'b0;
      check({tag, "_seen"}, resp_cnt - base, 1);
      check({tag, "_code"}, last_resp, exp);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] q_exp [5];
      int          base;
      int          cbase;
      q_exp = '{12'h000, 12'hFE1, 12'h000, 12'hFE1, 12'h000};

      rst_n = 1'b0; cmd = '0; cmd_rdy = 1'b0; heading = '0; heading_rdy = 1'b0;
      cal_done = 1'b0; lftIR = 1'b0; cntrIR = 1'b0; rghtIR = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_frwrd", frwrd, 0);
      check("rst_resp", resp, 0);
      check("rst_send_resp", send_resp, 0);
      check("rst_q_full", q_full, 0);
      check("rst_moving", moving, 0);
      check("rst_error", error, 0);
      rst_n = 1'b1;
      tick(2);

      // CAL: accept, strt_cal one cycle later, ACK on cal_done
      cmd = 16'h2000; cmd_rdy = 1'b1;
      #1;
      check("cal_clr", clr_cmd_rdy, 1);
      check("cal_strt_early", strt_cal, 0);
      @(posedge clk);
      #1 cmd_rdy = 1'b0;
      #1;
      check("cal_clr_one", clr_cmd_rdy, 0);
      check("cal_strt", strt_cal, 1);
      tick(1);
      check("cal_strt_one", strt_cal, 0);
      check("cal_no_resp", send_resp, 0);
      cal_done = 1'b1;
      #1;
      check("cal_resp_strobe", send_resp, 1);
      check("cal_resp_code", resp, 8'hA5);
      tick(1);
      cal_done = 1'b0;
      #1;
      check("cal_resp_one", send_resp, 0);

      // MOVE 2 squares: ramp by 0x20 saturating at 0x300, 4 boxes, ramp down by 0x40
      send_cmd(16'h4002);
      tick(2);
      check("mv_moving", moving, 1);
      check("mv_error", error, 0);
      hdg_pulses(1);
      check("mv_up1", frwrd, 10'h020);
      hdg_pulses(1);
      check("mv_up2", frwrd, 10'h040);
      hdg_pulses(22);
      check("mv_up24", frwrd, 10'h300);
      hdg_pulses(6);
      check("mv_sat", frwrd, 10'h300);
      repeat (4) cntr_pulse();
      tick(2);
      check("mv_hold", frwrd, 10'h300);
      hdg_pulses(1);
      check("mv_down1", frwrd, 10'h2C0);
      wait_resp("mv_done", 8'hA5);
      check("mv_zero", frwrd, 0);
      check("mv_no_fanfare", ff_cnt, 0);

      // MOVE_F 1 square: one fanfare pulse at the ramp-down transition
      send_cmd(16'h5001);
      tick(2);
      hdg_pulses(5);
      check("mf_up5", frwrd, 10'h0A0);
      check("mf_ff_before", ff_cnt, 0);
      repeat (2) cntr_pulse();
      tick(2);
      check("mf_ff_once", ff_cnt, 1);
      check("mf_hold", frwrd, 10'h0A0);
      wait_resp("mf_done", 8'hA5);
      check("mf_ff_total", ff_cnt, 1);

      // Queue: 4 MOVEs fill the queue during CAL, the 5th waits for the first pop
      send_cmd(16'h2000);
      tick(1);
      err_log.delete();
      send_cmd(16'h4000);
      send_cmd(16'h4010);
      send_cmd(16'h4000);
      send_cmd(16'h4010);
      check("q_full_set", q_full, 1);
      cmd = 16'h4000; cmd_rdy = 1'b1;
      #1;
      check("q_hold0", clr_cmd_rdy, 0);
      tick(3);
      check("q_hold3", clr_cmd_rdy, 0);
      cal_done = 1'b1;
      #1;
      check("q_cal_resp", send_resp, 1);
      tick(1);
      cal_done = 1'b0;
      #1;
      check("q_push_on_pop", clr_cmd_rdy, 1);
      tick(1);
      cmd_rdy = 1'b0;
      check("q_still_full", q_full, 1);
      for (int i = 0; i < 5; i++) wait_resp($sformatf("q_mv%0d", i), 8'hA5);
      check("q_log_size", err_log.size(), 5);
      for (int i = 0; i < 5; i++)
         check($sformatf("q_order%0d", i), (i < err_log.size()) ? err_log[i] : 12'hBAD, q_exp[i]);
      check("q_empty_full", q_full, 0);

      // STOP mid ramp-up with two queued commands
      send_cmd(16'h4003);
      tick(2);
      hdg_pulses(3);
      check("stop_up3", frwrd, 10'h060);
      send_cmd(16'h4001);
      send_cmd(16'h2000);
      cbase = cal_cnt;
      send_cmd(16'h7000);
      check("stop_hold", frwrd, 10'h060);
      base = resp_cnt;
      wait_resp("stop_done", 8'h5A);
      check("stop_zero", frwrd, 0);
      tick(20);
      check("stop_single_resp", resp_cnt - base, 1);
      check("stop_flushed", cal_cnt - cbase, 0);
      check("stop_idle", moving, 0);

      // Alignment window boundary: |error| == ERR_TOL holds ALIGN
      heading = 12'h02C;
      base = resp_cnt;
      send_cmd(16'h4000);
      tick(6);
      check("al_pos_edge_moving", moving, 1);
      check("al_pos_edge_frwrd", frwrd, 0);
      heading = 12'hFD4;
      hdg_pulses(3);
      check("al_neg_edge_frwrd", frwrd, 0);
      check("al_no_resp", resp_cnt - base, 0);
      heading = 12'hFD5;
      wait_resp("al_inside", 8'hA5);

      // STOP while aligning
      heading = 12'h200;
      send_cmd(16'h4000);
      tick(3);
      check("ab_moving", moving, 1);
      send_cmd(16'h7000);
      wait_resp("ab_done", 8'h5A);
      heading = 12'h000;

      // STOP and illegal opcodes while idle
      tick(2);
      cmd = 16'h7000; cmd_rdy = 1'b1;
      #1;
      check("idle_stop_clr", clr_cmd_rdy, 1);
      check("idle_stop_strobe", send_resp, 1);
      check("idle_stop_code", resp, 8'h5A);
      tick(1);
      cmd = 16'hF000;
      #1;
      check("ill_clr", clr_cmd_rdy, 1);
      check("ill_strobe", send_resp, 1);
      check("ill_code", resp, 8'h5A);
      tick(1);
      cmd = 16'h3123;
      #1;
      check("ill3_code", resp, 8'h5A);
      tick(1);
      cmd_rdy = 1'b0;
      tick(1);

      // TOUR: one tour_go pulse, no response
      base = resp_cnt;
      send_cmd(16'h6000);
      tick(4);
      check("tour_pulse", tour_cnt, 1);
      check("tour_no_resp", resp_cnt - base, 0);
      check("tour_idle", moving, 0);

      // Desired heading latch and IR nudges
      heading = 12'h12F;
      send_cmd(16'h4120);
      wait_resp("nud_move", 8'hA5);
      check("nud_zero", error, 12'h000);
      lftIR = 1'b1;
      #1;
      check("nud_left", error, 12'h1FF);
      rghtIR = 1'b1;
      #1;
      check("nud_left_prio", error, 12'h1FF);
      lftIR = 1'b0;
      #1;
      check("nud_right", error, 12'hE00);
      rghtIR = 1'b0;
      heading = 12'h80F;
      send_cmd(16'h4800);
      wait_resp("neg_move", 8'hA5);
      heading = 12'h000;
      #1;
      check("neg_desired", error, 12'h7F1);

      // Reset mid-move: speed clears at once, no response
      send_cmd(16'h4007);
      tick(2);
      hdg_pulses(4);
      check("rm_up4", frwrd, 10'h080);
      base = resp_cnt;
      #3 rst_n = 1'b0;
      #1;
      check("rm_frwrd", frwrd, 0);
      check("rm_moving", moving, 0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      check("rm_no_resp", resp_cnt - base, 0);
      check("rm_idle", moving, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
